// File: rtl/system_qsys_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : system_qsys_spi_slave
//  Description : SPI mode-0 slave with a CPU register port (rxdata, txdata,
//                status, control). SCLK/SS_n/MOSI are resynchronised into clk;
//                SCLK must run at clk/8 or slower. Defining SPI_SLAVE_EOP_EN
//                adds the end-of-packet register at address 6 and the EOP flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module system_qsys_spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  input  logic        read_n,
  input  logic        write_n,
  input  logic        spi_select,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata
);

  localparam logic [15:0] c_IRQ_MASK  = 16'h03F8;
  localparam logic [2:0]  c_WARM_DONE = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
  logic                   r_sclk_prev, r_ss_prev;
  logic [2:0]             r_warm;
  logic                   w_sclk, w_ss_n, w_mosi, w_warm;
  logic                   w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;

  logic       r_armed, r_rx_done, r_tx_loaded;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_shift, r_tx_shift;
  logic       w_tx_load;
  logic [7:0] w_tx_next;

  logic        r_rd_pend, r_wr_pend;
  logic [2:0]  r_addr;
  logic [15:0] r_wdata;
  logic        w_rd_req, w_wr_req, w_wr_tx, w_wr_st, w_wr_ctl, w_rd_rx;

  logic [7:0]  r_rx_holding, r_tx_holding;
  logic        r_rrdy, r_roe, r_toe, r_tx_primed;
  logic [15:0] r_control;
  logic        w_tmt, w_eop_flag;
  logic [15:0] w_status, w_rd_mux, w_eop_rd;

  // Resynchronise the SPI pins; r_warm counts until the chain holds only post-reset samples
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_ss_prev   <= 1'b1;
      r_warm      <= 3'd0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      r_ss_prev   <= r_ss_sync[SYNC_STAGES-1];
      if (r_warm != c_WARM_DONE) r_warm <= r_warm + 3'd1;
    end
  end

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss_n = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  // Edges are ignored until the pipeline is flushed, so a select held low
  // through reset does not look like a fresh falling edge.
  assign w_warm      = (r_warm == c_WARM_DONE);
  assign w_sclk_rise = w_warm &  w_sclk & ~r_sclk_prev;
  assign w_sclk_fall = w_warm & ~w_sclk &  r_sclk_prev;
  assign w_ss_fall   = w_warm & ~w_ss_n &  r_ss_prev;
  assign w_ss_rise   = w_warm &  w_ss_n & ~r_ss_prev;

  assign w_tx_next = r_tx_primed ? r_tx_holding : 8'h00;
  assign w_tx_load = ~w_ss_rise & (w_ss_fall | (r_armed & w_sclk_fall & (r_bit_cnt == 3'd0)));

  // Serial shift engine: sample MOSI on SCLK rise, advance MISO on SCLK fall
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_armed     <= 1'b0;
      r_bit_cnt   <= 3'd0;
      r_rx_shift  <= 8'h00;
      r_rx_done   <= 1'b0;
      r_tx_shift  <= 8'h00;
      r_tx_loaded <= 1'b0;
    end else begin
      r_rx_done <= 1'b0;
      if (w_ss_rise) begin
        r_armed     <= 1'b0;
        r_bit_cnt   <= 3'd0;
        r_tx_shift  <= 8'h00;
        r_tx_loaded <= 1'b0;
      end else if (w_ss_fall) begin
        r_armed     <= 1'b1;
        r_bit_cnt   <= 3'd0;
        r_tx_shift  <= w_tx_next;
        r_tx_loaded <= r_tx_primed;
      end else if (r_armed) begin
        if (w_sclk_rise) begin
          r_rx_shift <= {r_rx_shift[6:0], w_mosi};
          if (r_bit_cnt == 3'd7) begin
            r_bit_cnt   <= 3'd0;
            r_rx_done   <= 1'b1;
            r_tx_loaded <= 1'b0;
          end else begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end else if (w_sclk_fall) begin
          if (r_bit_cnt == 3'd0) begin
            r_tx_shift  <= w_tx_next;
            r_tx_loaded <= r_tx_primed;
          end else begin
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
          end
        end
      end
    end
  end

  assign MISO = w_ss_n ? 1'b1 : r_tx_shift[7];

  // A strobe is taken on the first cycle only; the pending flags mark the commit cycle
  assign w_rd_req = spi_select & ~read_n  & ~(r_rd_pend | r_wr_pend);
  assign w_wr_req = spi_select & ~write_n & ~(r_rd_pend | r_wr_pend);
  assign w_wr_tx  = r_wr_pend & (r_addr == 3'd1);
  assign w_wr_st  = r_wr_pend & (r_addr == 3'd2);
  assign w_wr_ctl = r_wr_pend & (r_addr == 3'd3);
  assign w_rd_rx  = r_rd_pend & (r_addr == 3'd0);

  // Capture the CPU access and present read data for the second cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_pend   <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_addr      <= 3'd0;
      r_wdata     <= 16'h0000;
      data_to_cpu <= 16'h0000;
    end else begin
      r_rd_pend <= w_rd_req;
      r_wr_pend <= w_wr_req;
      if (w_rd_req | w_wr_req) begin
        r_addr  <= mem_addr;
        r_wdata <= data_from_cpu;
      end
      if (w_rd_req) data_to_cpu <= w_rd_mux;
    end
  end

  // Status flags and holding registers; hardware set wins over a CPU clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rx_holding <= 8'h00;
      r_tx_holding <= 8'h00;
      r_rrdy       <= 1'b0;
      r_roe        <= 1'b0;
      r_toe        <= 1'b0;
      r_tx_primed  <= 1'b0;
      r_control    <= 16'h0000;
    end else begin
      if (r_rx_done) begin
        r_rx_holding <= r_rx_shift;
        r_rrdy       <= 1'b1;
      end else if (w_rd_rx) begin
        r_rrdy <= 1'b0;
      end
      if (r_rx_done && r_rrdy) r_roe <= 1'b1;
      else if (w_wr_st)        r_roe <= 1'b0;
      if (w_wr_tx && r_tx_primed) r_toe <= 1'b1;
      else if (w_wr_st)           r_toe <= 1'b0;
      if (w_tx_load && r_tx_primed) begin
        r_tx_primed <= 1'b0;
      end else if (w_wr_tx && !r_tx_primed) begin
        r_tx_primed  <= 1'b1;
        r_tx_holding <= r_wdata[7:0];
      end
      if (w_wr_ctl) r_control <= r_wdata & c_IRQ_MASK;
    end
  end

`ifdef SPI_SLAVE_EOP_EN
  logic [15:0] r_eop;
  logic        r_eop_flag;

  // End-of-packet match on received bytes and on bytes queued for transmit
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_eop      <= 16'h0000;
      r_eop_flag <= 1'b0;
    end else begin
      if (r_wr_pend && r_addr == 3'd6) r_eop <= r_wdata;
      if ((r_rx_done && r_rx_shift == r_eop[7:0]) || (w_wr_tx && r_wdata[7:0] == r_eop[7:0]))
        r_eop_flag <= 1'b1;
      else if (w_wr_st)
        r_eop_flag <= 1'b0;
    end
  end

  assign w_eop_flag = r_eop_flag;
  assign w_eop_rd   = r_eop;
`else
  assign w_eop_flag = 1'b0;
  assign w_eop_rd   = 16'h0000;
`endif

  assign w_tmt    = ~r_tx_primed & ~(~w_ss_n & r_tx_loaded);
  assign w_status = {6'd0, w_eop_flag, r_roe | r_toe, r_rrdy, ~r_tx_primed, w_tmt,
                     r_toe, r_roe, 3'd0};

  // Register-map read multiplexer
  always_comb begin
    w_rd_mux = 16'h0000;
    case (mem_addr)
      3'd0:    w_rd_mux = {8'h00, r_rx_holding};
      3'd2:    w_rd_mux = w_status;
      3'd3:    w_rd_mux = r_control;
      3'd6:    w_rd_mux = w_eop_rd;
      default: w_rd_mux = 16'h0000;
    endcase
  end

  // Interrupt follows the enabled status bits one clock later
  always_ff @(posedge clk) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= |(w_status & r_control);
  end

  assign dataavailable = r_rrdy;
  assign readyfordata  = ~r_tx_primed;

endmodule
`default_nettype wire

// File: tb/tb_system_qsys_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_system_qsys_spi_slave
//  Description : Scoreboard bench for system_qsys_spi_slave: a behavioural
//                register/flag model predicts CPU reads and MISO bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_system_qsys_spi_slave;

  localparam int H = 8;  // SPI half period in clk cycles

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        SCLK = 1'b0, SS_n = 1'b1, MOSI = 1'b0;
  logic        read_n = 1'b1, write_n = 1'b1, spi_select = 1'b0;
  logic [2:0]  mem_addr = 3'd0;
  logic [15:0] data_from_cpu = 16'h0000;
  logic        MISO, irq, dataavailable, readyfordata;
  logic [15:0] data_to_cpu;

  always #5 clk = ~clk;

  system_qsys_spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .mem_addr(mem_addr), .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
    .read_n(read_n), .write_n(write_n), .spi_select(spi_select), .irq(irq),
    .dataavailable(dataavailable), .readyfordata(readyfordata)
  );

  int errors = 0, checks = 0;

  typedef struct packed { logic [15:0] d; logic irq; } rd_exp_t;
  rd_exp_t    exp_rd[$];
  logic [7:0] exp_miso[$];

  // behavioural model of the programmer-visible state
  bit [7:0]  m_rxh, m_txh, m_cur;
  bit        m_rrdy, m_roe, m_toe, m_primed, m_eopf;
  bit [15:0] m_ctrl, m_eopv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_rxh = 0; m_txh = 0; m_cur = 0; m_rrdy = 0; m_roe = 0; m_toe = 0;
    m_primed = 0; m_eopf = 0; m_ctrl = 0; m_eopv = 0;
  endfunction

  function automatic logic [15:0] m_status();
    return {6'd0, m_eopf, m_roe | m_toe, m_rrdy, ~m_primed, ~m_primed, m_toe, m_roe, 3'd0};
  endfunction

  function automatic logic m_irq();
    return |(m_status() & m_ctrl);
  endfunction

  function automatic logic [15:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {8'h00, m_rxh};
      3'd2: return m_status();
      3'd3: return m_ctrl;
`ifdef SPI_SLAVE_EOP_EN
      3'd6: return m_eopv;
`endif
      default: return 16'h0000;
    endcase
  endfunction

  function automatic void m_write(input logic [2:0] a, input logic [15:0] d);
    case (a)
      3'd1: begin
`ifdef SPI_SLAVE_EOP_EN
        if (d[7:0] == m_eopv[7:0]) m_eopf = 1;
`endif
        if (!m_primed) begin m_txh = d[7:0]; m_primed = 1; end
        else m_toe = 1;
      end
      3'd2: begin m_roe = 0; m_toe = 0; m_eopf = 0; end
      3'd3: m_ctrl = d & 16'h03F8;
`ifdef SPI_SLAVE_EOP_EN
      3'd6: m_eopv = d;
`endif
      default: ;
    endcase
  endfunction

  function automatic logic [7:0] m_load();
    if (m_primed) begin m_primed = 0; return m_txh; end
    return 8'h00;
  endfunction

  function automatic void m_rx(input logic [7:0] b);
    if (m_rrdy) m_roe = 1;
    m_rxh = b;
    m_rrdy = 1;
`ifdef SPI_SLAVE_EOP_EN
    if (b == m_eopv[7:0]) m_eopf = 1;
`endif
  endfunction

  // read monitor: second cycle of each read access carries data
  bit mon_rd = 0;
  always @(posedge clk) mon_rd <= spi_select && !read_n && !mon_rd;

  always @(negedge clk) begin : rd_mon
    rd_exp_t e;
    if (mon_rd) begin
      if (exp_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got %h expected none", data_to_cpu);
      end else begin
        e = exp_rd.pop_front();
        check("rd_data", 32'(data_to_cpu), 32'(e.d));
        check("rd_irq", 32'(irq), 32'(e.irq));
      end
    end
  end

  // MISO monitor: compares each byte the master collected
  event       miso_ev;
  logic [7:0] miso_got;
  always @(miso_ev) begin
    if (exp_miso.size() == 0) begin
      checks++; errors++;
      $display("FAIL miso_unexpected: got %h expected none", miso_got);
    end else begin
      check("miso_byte", 32'(miso_got), 32'(exp_miso.pop_front()));
    end
  end

  task automatic cpu_read(input logic [2:0] a);
    rd_exp_t e;
    e.d = m_read(a); e.irq = m_irq();
    exp_rd.push_back(e);
    if (a == 3'd0) m_rrdy = 0;
    @(negedge clk); mem_addr = a; spi_select = 1; read_n = 0;
    @(negedge clk);
    @(negedge clk); read_n = 1; spi_select = 0;
    @(negedge clk);
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk); mem_addr = a; data_from_cpu = d; spi_select = 1; write_n = 0;
    @(negedge clk);
    @(negedge clk); write_n = 1; spi_select = 0; data_from_cpu = 16'($urandom);
    @(negedge clk);
    m_write(a, d);
  endtask

  task automatic spi_start();
    SS_n = 0;
    repeat (H) @(negedge clk);
    m_cur = m_load();
  endtask

  task automatic spi_bit(input logic b, output logic m);
    MOSI = b;
    repeat (H) @(negedge clk);
    m = MISO; SCLK = 1;
    repeat (H) @(negedge clk);
    SCLK = 0;
  endtask

  task automatic spi_end();
    repeat (H) @(negedge clk);
    SS_n = 1;
    repeat (2*H) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] b, input bit mid, input logic [7:0] v1, input logic [7:0] v2);
    logic [7:0] got;
    logic m;
    got = 8'h00;
    exp_miso.push_back(m_cur);
    for (int i = 7; i >= 0; i--) begin
      spi_bit(b[i], m);
      got[i] = m;
      if (mid && i == 4) begin
        cpu_write(3'd1, {8'h00, v1});
        cpu_write(3'd1, {8'h00, v2});
      end
    end
    m_rx(b);
    m_cur = m_load();
    miso_got = got;
    -> miso_ev;
  endtask

  // bytes[7:0] goes first; mid-byte txdata writes happen in the first byte
  task automatic frame(input int n, input logic [23:0] bytes, input bit mid,
                       input logic [7:0] v1, input logic [7:0] v2);
    spi_start();
    for (int k = 0; k < n; k++) spi_byte(bytes[8*k +: 8], mid && k == 0, v1, v2);
    spi_end();
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic m;
    m_reset();
    // reset values
    repeat (3) @(negedge clk);
    check("rst_data_to_cpu", 32'(data_to_cpu), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_miso", 32'(MISO), 32'h1);
    check("rst_dataavailable", 32'(dataavailable), 32'h0);
    check("rst_readyfordata", 32'(readyfordata), 32'h1);
    reset_n = 1;
    repeat (8) @(negedge clk);
    cpu_read(3'd2);

    // receive with irq on RRDY
    cpu_write(3'd3, 16'h0080);
    frame(1, 24'h0000A5, 0, 8'h00, 8'h00);
    check("rrdy_after_rx", 32'(dataavailable), 32'h1);
    check("irq_after_rx", 32'(irq), 32'(m_irq()));
    cpu_read(3'd2);
    cpu_read(3'd0);
    repeat (4) @(negedge clk);
    check("rrdy_after_read", 32'(dataavailable), 32'h0);
    check("irq_after_read", 32'(irq), 32'(m_irq()));

    // transmit a primed byte
    cpu_write(3'd1, 16'h003C);
    check("trdy_primed", 32'(readyfordata), 32'(!m_primed));
    frame(1, 24'(8'($urandom)), 0, 8'h00, 8'h00);
    check("trdy_after_load", 32'(readyfordata), 32'(!m_primed));
    cpu_read(3'd0);

    // overrun
    frame(2, 24'h002211, 0, 8'h00, 8'h00);
    cpu_read(3'd2);
    cpu_read(3'd0);
    cpu_write(3'd2, 16'hFFFF);
    cpu_read(3'd2);

    // transmit overrun while a byte is in flight
    frame(2, 24'h00C3B4, 1, 8'h5A, 8'hC3);
    cpu_read(3'd2);
    cpu_write(3'd2, 16'h0000);
    cpu_read(3'd0);

    // partial byte discarded, then full byte
    spi_start();
    for (int i = 0; i < 4; i++) spi_bit(1'b1, m);
    spi_end();
    cpu_read(3'd2);
    frame(1, 24'h000081, 0, 8'h00, 8'h00);
    cpu_read(3'd0);

    // reset in mid-byte, then clocks without a fresh select edge
    cpu_write(3'd1, 16'h0077);
    spi_start();
    for (int i = 0; i < 3; i++) spi_bit(1'b1, m);
    reset_n = 0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    m_reset();
    for (int i = 0; i < 8; i++) spi_bit(1'b1, m);
    spi_end();
    cpu_read(3'd2);
    frame(1, 24'(8'($urandom)), 0, 8'h00, 8'h00);
    cpu_read(3'd0);

    // end-of-packet register (reads 0 and has no effect when not built in)
    cpu_write(3'd6, 16'h000D);
    cpu_read(3'd6);
    cpu_write(3'd3, 16'h0200);
    frame(1, 24'h00000D, 0, 8'h00, 8'h00);
    cpu_read(3'd2);
    cpu_read(3'd0);
    cpu_write(3'd2, 16'h0000);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: cpu_write(3'd1, 16'($urandom));
        1: cpu_write(3'd3, 16'($urandom));
        2: cpu_write(3'd2, 16'($urandom));
        3: frame($urandom_range(1, 3), 24'($urandom), 1'($urandom_range(0, 1)),
                 8'($urandom), 8'($urandom));
        4: cpu_read(3'($urandom_range(0, 7)));
        default: begin
          cpu_write(3'($urandom_range(4, 7)), 16'($urandom));
          cpu_read(3'($urandom_range(4, 7)));
        end
      endcase
      cpu_read(3'd2);
    end

    repeat (10) @(negedge clk);
    check("rd_queue_drained", 32'(exp_rd.size()), 32'h0);
    check("miso_queue_drained", 32'(exp_miso.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
